voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Polyphony controller that sits between the 10 note switches/keys and a pool of NUM_VOICES shared tone generators.
- It scans key levels, detects press and release events, and assigns each pressed key to a free voice.
- When all voices are busy, it steals the least-recently-allocated voice.
- Per voice it drives a key index, an on flag and a one-hot note selector in the existing 10-bit noteSelector format.
- The mixer then sums only the generators whose voice is on.

Parameters:
- NUM_KEYS, 10, number of key inputs (one-hot selector width).
- NUM_VOICES, 4, number of shared tone generators (>=2).
- KEY_W, 4, width of a key index (>= clog2(NUM_KEYS)).
- AGE_W, 2, width of a per-voice LRU age (clog2(NUM_VOICES)).

Ports:
- Clk, input, 1, system clock (CLOCK_50 domain).
- Resetn, input, 1, asynchronous active-low reset.
- key_level, input, NUM_KEYS, raw key/switch levels (1 = pressed); asynchronous to Clk.
- voice_on, output, NUM_VOICES, bit v = voice v currently sounding.
- voice_key, output, NUM_VOICES*KEY_W, key index owned by voice v, in slice [v*KEY_W +: KEY_W].
- voice_sel, output, NUM_VOICES*NUM_KEYS, one-hot noteSelector for voice v; all zero when voice v is off.
- note_on_pulse, output, NUM_VOICES, 1-cycle pulse when voice v is (re)assigned; used to retrigger an envelope.
- steal_pulse, output, 1, 1-cycle pulse when an allocation steals an active voice.

Behaviour:
- Reset (async, Resetn=0):
  - voice_on=0, voice_key=0, voice_sel=0, note_on_pulse=0, steal_pulse=0.
  - Both synchronizer stages cleared; tracked[]=0; scan_idx=0; state=SCAN.
  - age[v]=v, so voice NUM_VOICES-1 is initially oldest.
- Deassertion is used directly; no internal reset synchronizer.
- Input sync: key_level passes through a 2-flop synchronizer to give ks[]. Only ks is used internally.
- tracked[k] records the last key level the FSM acted on.
- FSM states SCAN, ALLOC, RELEASE:
  - SCAN, ks[scan_idx]==tracked[scan_idx]: advance scan_idx; wrap from NUM_KEYS-1 to 0. Stay in SCAN.
  - SCAN, ks=1 and tracked=0: latch cur_key=scan_idx; go to ALLOC.
  - SCAN, ks=0 and tracked=1: latch cur_key; go to RELEASE.
  - ALLOC (1 cycle):
    - Target = lowest-index voice with voice_on=0.
    - If no voice is free, target = the voice with age==NUM_VOICES-1, and steal_pulse=1.
    - Set voice_on[t]=1, voice_key[t]=cur_key, note_on_pulse[t]=1, tracked[cur_key]=1.
    - LRU update: with a = old age[t], every voice with age<a increments and age[t] becomes 0. Ages remain a permutation of 0..NUM_VOICES-1.
    - Advance scan_idx; return to SCAN.
  - RELEASE (1 cycle):
    - Clear tracked[cur_key].
    - Any voice with voice_on=1 and voice_key==cur_key gets voice_on cleared. voice_key is retained; ages are unchanged.
    - If no voice matches (the key's voice was stolen), there is no voice change.
    - Advance scan_idx; return to SCAN.
- Stolen key: the displaced key keeps tracked=1, so it does not re-trigger while still held. Its later release is a no-op.
- Key levels are sampled once per visit. A press and release that both fall between two visits to the same key are invisible; this is by design.
- Latency: key_level change to voice output update is at most 2 (sync) + 2*NUM_KEYS (one full scan, each key costing 1 or 2 cycles) + 1 cycles, i.e. 23 cycles at the defaults.
- voice_sel is registered together with voice_on/voice_key in the same cycle:
  - sel = 1<<voice_key when on, else 0.
  - A voice_key value >= NUM_KEYS is unreachable.
- note_on_pulse and steal_pulse are high for exactly one cycle and zero in every other state.
- Ownership invariant: at most one active voice owns a given key.
- Reset asserted mid-ALLOC/RELEASE aborts the operation; all state returns to reset values immediately.

Test Plan:
- Reset, then raise key_level[0] -> within 23 cycles voice_on=4'b0001, voice_key[0]=0, voice_sel slice0=10'd1, one note_on_pulse[0], steal_pulse never set.
- Press keys 0,1,2,3 one at a time, each after the previous allocation -> voices 0..3 hold keys 0..3. Then press key 5 -> voice 0 reassigned to key 5, slice0=10'd32, steal_pulse and note_on_pulse[0] one cycle each, voice_on=4'b1111.
- Continuing: release key 0 (stolen) -> no output change for 3 full scans. Release key 2 -> voice_on=4'b1011, slice2=0. Press key 9 -> voice 2 gets key 9, slice2=10'd512, no steal.
- Raise keys 3 and 7 in the same cycle from reset -> key 3 gets voice 0 and key 7 gets voice 1 (scan order); note_on pulses on different cycles.
- Hold key 4 pressed, pulse Resetn low for 1 cycle mid-scan -> all outputs 0 asynchronously. After release, key 4 is re-allocated to voice 0 within 23 cycles.
- Toggle key 6 high then low within 2 cycles while scan_idx is away from 6 -> no allocation and no pulses.

Source files
------------

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Scans key levels and assigns pressed keys to a pool of shared
//            tone generators, stealing the least-recently-allocated voice.
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_KEYS   = 10,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 4,
    parameter int AGE_W      = 2
) (
    input  logic                           Clk,
    input  logic                           Resetn,
    input  logic [NUM_KEYS-1:0]            key_level,
    output logic [NUM_VOICES-1:0]          voice_on,
    output logic [NUM_VOICES*KEY_W-1:0]    voice_key,
    output logic [NUM_VOICES*NUM_KEYS-1:0] voice_sel,
    output logic [NUM_VOICES-1:0]          note_on_pulse,
    output logic                           steal_pulse
);

    localparam int                 C_VIDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [KEY_W-1:0]   C_LAST_KEY = KEY_W'(NUM_KEYS - 1);
    localparam logic [AGE_W-1:0]   C_OLDEST   = AGE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_ALLOC   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [NUM_KEYS-1:0]    r_sync1;
    logic [NUM_KEYS-1:0]    r_ks;
    logic [NUM_KEYS-1:0]    r_tracked;
    logic [KEY_W-1:0]       r_scan_idx;
    logic [KEY_W-1:0]       r_cur_key;

    logic [NUM_VOICES-1:0]  r_voice_on;
    logic [KEY_W-1:0]       r_vkey [NUM_VOICES];
    logic [NUM_KEYS-1:0]    r_vsel [NUM_VOICES];
    logic [AGE_W-1:0]       r_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0]  r_note_on;
    logic                   r_steal;

    logic                   w_ks_cur;
    logic                   w_trk_cur;
    logic [KEY_W-1:0]       w_scan_next;
    logic                   w_free_found;
    logic [C_VIDX_W-1:0]    w_free_idx;
    logic [C_VIDX_W-1:0]    w_oldest_idx;
    logic [C_VIDX_W-1:0]    w_target;
    logic [AGE_W-1:0]       w_tgt_age;
    logic [NUM_KEYS-1:0]    w_cur_onehot;
    logic [NUM_VOICES-1:0]  w_rel_match;

    // Two-flop synchronizer; key_level is asynchronous to Clk
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1 <= '0;
            r_ks    <= '0;
        end else begin
            r_sync1 <= key_level;
            r_ks    <= r_sync1;
        end
    end

    assign w_ks_cur     = r_ks[r_scan_idx];
    assign w_trk_cur    = r_tracked[r_scan_idx];
    assign w_scan_next  = (r_scan_idx == C_LAST_KEY) ? '0 : r_scan_idx + KEY_W'(1);
    assign w_cur_onehot = NUM_KEYS'(1) << r_cur_key;

    // Lowest-index free voice wins; otherwise the oldest voice is stolen
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_oldest_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_voice_on[v]) begin
                w_free_found = 1'b1;
                w_free_idx   = C_VIDX_W'(v);
            end
            if (r_age[v] == C_OLDEST) begin
                w_oldest_idx = C_VIDX_W'(v);
            end
        end
    end

    assign w_target  = w_free_found ? w_free_idx : w_oldest_idx;
    assign w_tgt_age = r_age[w_target];

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice_out
            assign w_rel_match[v]                     = r_voice_on[v] && (r_vkey[v] == r_cur_key);
            assign voice_key[v*KEY_W +: KEY_W]        = r_vkey[v];
            assign voice_sel[v*NUM_KEYS +: NUM_KEYS]  = r_vsel[v];
        end
    endgenerate

    assign voice_on      = r_voice_on;
    assign note_on_pulse = r_note_on;
    assign steal_pulse   = r_steal;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN: begin
                if (w_ks_cur && !w_trk_cur) begin
                    w_state_nxt = ST_ALLOC;
                end else if (!w_ks_cur && w_trk_cur) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_ALLOC:   w_state_nxt = ST_SCAN;
            ST_RELEASE: w_state_nxt = ST_SCAN;
            default:    w_state_nxt = ST_SCAN;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_tracked  <= '0;
            r_scan_idx <= '0;
            r_cur_key  <= '0;
            r_voice_on <= '0;
            r_note_on  <= '0;
            r_steal    <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_vkey[v] <= '0;
                r_vsel[v] <= '0;
                r_age[v]  <= AGE_W'(v);
            end
        end else begin
            r_note_on <= '0;
            r_steal   <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (w_ks_cur == w_trk_cur) begin
                        r_scan_idx <= w_scan_next;
                    end else begin
                        r_cur_key <= r_scan_idx;
                    end
                end
                ST_ALLOC: begin
                    r_voice_on[w_target] <= 1'b1;
                    r_vkey[w_target]     <= r_cur_key;
                    r_vsel[w_target]     <= w_cur_onehot;
                    r_note_on[w_target]  <= 1'b1;
                    r_steal              <= !w_free_found;
                    r_tracked[r_cur_key] <= 1'b1;
                    r_scan_idx           <= w_scan_next;
                    // Move target to youngest; voices younger than it age by one
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (C_VIDX_W'(v) == w_target) begin
                            r_age[v] <= '0;
                        end else if (r_age[v] < w_tgt_age) begin
                            r_age[v] <= r_age[v] + AGE_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    r_tracked[r_cur_key] <= 1'b0;
                    r_scan_idx           <= w_scan_next;
                    // A stolen key finds no owner here, so its release is a no-op
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (w_rel_match[v]) begin
                            r_voice_on[v] <= 1'b0;
                            r_vsel[v]     <= '0;
                        end
                    end
                end
                default: begin
                    r_scan_idx <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
